// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache block-miss interface: programmable-latency
// block loads and write-backs against a small aliased backing store.
module cache_mem_responder #(
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_SIZE  = 32,
  parameter int BLOCK_SIZE = 6,
  parameter int MEM_IDX    = 4,
  parameter int LATENCY    = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      addr_valid_out,
  input  logic [ADDR_SIZE-1:0]                      addr_out_m,
  input  logic                                      rw_out,
  input  logic                                      ready_ld,
  output logic                                      valid_ld,
  output logic [2**BLOCK_SIZE-1:0][DATA_SIZE-1:0]   data_in_m,
  input  logic                                      valid_wb,
  input  logic [2**BLOCK_SIZE-1:0][DATA_SIZE-1:0]   data_out_m,
  output logic                                      ready_wb,
  output logic                                      busy
);

  localparam int BLOCKS  = 2**BLOCK_SIZE;
  localparam int ENTRIES = 2**MEM_IDX;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD, S_WB} state_t;

  state_t                              state_q, state_d;
  logic [7:0]                          cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0]                req_addr_q, req_addr_d;
  logic [ADDR_SIZE-1:0]                last_addr_q, last_addr_d;
  logic                                req_rw_q, req_rw_d;
  logic                                last_rw_q, last_rw_d;
  logic                                hold_q, hold_d;
  logic                                valid_ld_q, valid_ld_d;
  logic                                ready_wb_q, ready_wb_d;
  logic                                busy_q, busy_d;
  logic [ENTRIES-1:0]                  vld_q, vld_d;
  logic [BLOCKS-1:0][DATA_SIZE-1:0]    data_in_q, data_in_d;
  logic [BLOCKS-1:0][DATA_SIZE-1:0]    mem_q [ENTRIES];
  logic [MEM_IDX-1:0]                  req_ei_s;
  logic                                stale_s;
  logic                                done_s;
  logic                                mem_we_s;

  // Word idx of the fill pattern for an unwritten entry: block base address | idx.
  function automatic logic [DATA_SIZE-1:0] fill_word(input logic [ADDR_SIZE-1:0] addr,
                                                     input int unsigned idx);
    logic [ADDR_SIZE-1:0] base;
    base = (addr >> BLOCK_SIZE) << BLOCK_SIZE;
    return DATA_SIZE'(base | ADDR_SIZE'(idx));
  endfunction

  assign req_ei_s = req_addr_q[BLOCK_SIZE +: MEM_IDX];
  assign stale_s  = hold_q && (addr_out_m == last_addr_q) && (rw_out == last_rw_q);
  assign done_s   = ((state_q == S_LOAD) && ready_ld) || ((state_q == S_WB) && valid_wb);
  assign mem_we_s = (state_q == S_WB) && valid_wb;

  // Next-state and next-output computation for the request FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_addr_d  = req_addr_q;
    req_rw_d    = req_rw_q;
    valid_ld_d  = valid_ld_q;
    ready_wb_d  = ready_wb_q;
    busy_d      = busy_q;
    vld_d       = vld_q;
    data_in_d   = data_in_q;
    case (state_q)
      S_IDLE: begin
        if (addr_valid_out && !stale_s) begin
          req_addr_d = addr_out_m;
          req_rw_d   = rw_out;
          cnt_d      = 8'(LATENCY - 1);
          busy_d     = 1'b1;
          state_d    = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          if (!req_rw_q) begin
            state_d    = S_LOAD;
            valid_ld_d = 1'b1;
            // Snapshot the block now so the load channel stays stable under back-pressure.
            for (int i = 0; i < BLOCKS; i++) begin
              data_in_d[i] = vld_q[req_ei_s] ? mem_q[req_ei_s][i]
                                             : fill_word(req_addr_q, i);
            end
          end else begin
            state_d    = S_WB;
            ready_wb_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_LOAD: begin
        if (ready_ld) begin
          valid_ld_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WB: begin
        if (valid_wb) begin
          ready_wb_d      = 1'b0;
          busy_d          = 1'b0;
          vld_d[req_ei_s] = 1'b1;
          state_d         = S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      default: begin
        state_d    = S_IDLE;
        valid_ld_d = 1'b0;
        ready_wb_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Stale-request tracking: a completed request is remembered until addr_valid_out drops.
  always_comb begin
    last_addr_d = last_addr_q;
    last_rw_d   = last_rw_q;
    hold_d      = hold_q;
    if (done_s) begin
      last_addr_d = req_addr_q;
      last_rw_d   = req_rw_q;
      hold_d      = 1'b1;
    end else if (!addr_valid_out) begin
      hold_d = 1'b0;
    end else begin
      hold_d = hold_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      req_addr_q  <= '0;
      req_rw_q    <= 1'b0;
      last_addr_q <= '0;
      last_rw_q   <= 1'b0;
      hold_q      <= 1'b0;
      valid_ld_q  <= 1'b0;
      ready_wb_q  <= 1'b0;
      busy_q      <= 1'b0;
      vld_q       <= '0;
      data_in_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_addr_q  <= req_addr_d;
      req_rw_q    <= req_rw_d;
      last_addr_q <= last_addr_d;
      last_rw_q   <= last_rw_d;
      hold_q      <= hold_d;
      valid_ld_q  <= valid_ld_d;
      ready_wb_q  <= ready_wb_d;
      busy_q      <= busy_d;
      vld_q       <= vld_d;
      data_in_q   <= data_in_d;
    end
  end

  // Backing-store data; deliberately not reset, validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[req_ei_s] <= data_out_m;
    end
  end

  assign valid_ld  = valid_ld_q;
  assign ready_wb  = ready_wb_q;
  assign busy      = busy_q;
  assign data_in_m = data_in_q;

endmodule
